sum_accumulator: RTL
====================

// Module: sum_accumulator
// PURPOSE
//  Downstream consumer of the ripple-carry adder stage.
//  Takes the (DATA_WIDTH+1)-bit sum, carry-out included, through a valid/ready handshake.
//  Accumulates MAX_COUNT sums into an ACC_WIDTH register, saturating on overflow.
//  Presents the batch total to the next stage, holding it until that stage accepts it.
// PARAMETERS
//  DATA_WIDTH  8   adder operand width; the input sum is DATA_WIDTH+1 bits
//  ACC_WIDTH   16  accumulator width; must be >= DATA_WIDTH+1 (elaboration assertion)
//  MAX_COUNT   4   sums per batch; must be >= 1
//  CNT_W       $clog2(MAX_COUNT+1), localparam
// PORTS
//  clk        in   1             single clock, all logic on posedge
//  reset      in   1             synchronous, active-high
//  in_valid   in   1             in_sum is valid
//  in_sum     in   DATA_WIDTH+1  sum from the adder stage, treated as unsigned
//  in_ready   out  1             block accepts a sample this cycle
//  flush      in   1             close the current batch early
//  out_valid  out  1             batch result is valid
//  out_ready  in   1             downstream accepts the result
//  out_acc    out  ACC_WIDTH     batch total, saturated
//  out_count  out  CNT_W         number of samples in the batch
//  out_sat    out  1             saturation occurred in this batch (sticky per batch)
// BEHAVIOUR
//  States: ACCUM, DONE. Reset -> ACCUM; acc=0, cnt=0, out_sat=0, out_valid=0.
//  in_ready = (state==ACCUM); out_valid = (state==DONE). Both decoded from the state register.
//  Beat: in_valid && in_ready.
//   - sum_ext = acc + zero-extended in_sum, computed at ACC_WIDTH+1 bits.
//   - If sum_ext[ACC_WIDTH] is set: acc <= all ones and out_sat <= 1. Otherwise acc <= sum_ext[ACC_WIDTH-1:0].
//   - cnt <= cnt + 1.
//  ACCUM -> DONE when either condition holds:
//   - a beat occurs with cnt == MAX_COUNT-1;
//   - flush is high and (cnt > 0 or a beat occurs in the same cycle).
//   A simultaneous beat is included in the batch.
//  flush with cnt==0 and no beat is ignored. flush has no effect in DONE.
//  Latency: the last sample is accepted in cycle T; out_valid is high in cycle T+1.
//  DONE:
//   - out_acc, out_count and out_sat are stable while out_valid && !out_ready.
//   - in_valid is ignored; in_ready is 0.
//  out_valid && out_ready -> ACCUM. Same edge: acc=0, cnt=0, out_sat=0.
//   - No bypass: the first sample of the next batch is accepted at T+1 or later.
//   - Throughput: MAX_COUNT+1 cycles per batch, at best.
//  out_acc = acc and out_count = cnt in every state. Their values are only meaningful while out_valid is high.
//  Reset is synchronous and overrides everything, including mid-batch and in DONE. A pending result is discarded.
//  Once saturated, acc stays at all ones for the rest of the batch; later beats do not wrap.
// STRUCTURE
//  Shared package sum_accumulator_pkg:
//   - typedef enum logic {ACCUM, DONE} acc_state_t;
//   - function sat_add(acc, in), returning {sat, result}.
//  Sub-module sat_adder, parameterised (ACC_WIDTH, IN_WIDTH):
//   - combinational acc + in with saturation flag;
//   - instantiated once.
//  Top level holds the state register, count, acc and sticky flag.
// TESTING  (DATA_WIDTH=8, ACC_WIDTH=10, MAX_COUNT=4)
//  Full batch: sums 100, 200, 300, 400 back to back, out_ready=1.
//   -> out_valid 1 cycle after the 4th beat; out_acc=1000, out_count=4, out_sat=0.
//  Saturation: sums 511, 511, 511, 1.
//   -> after the 3rd beat acc=1023 and sat=1; final out_acc=1023, out_sat=1 (no wrap to 0).
//  Flush: sums 5, 7, then flush with in_valid=0.
//   -> out_acc=12, out_count=2. flush in an idle ACCUM with cnt=0 -> no out_valid.
//  Flush with beat: sums 5, then 7 with flush high in the same cycle.
//   -> out_acc=12, out_count=2.
//  Backpressure: complete a batch, hold out_ready=0 for 5 cycles with in_valid=1.
//   -> in_ready=0 and outputs stable for all 5 cycles.
//   -> after out_ready=1, the next batch starts from acc=0.
//  Reset: assert reset after 2 beats, and again while in DONE.
//   -> next cycle in_ready=1, out_valid=0; the following batch of 1, 1, 1, 1 gives out_acc=4.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// Shared types and helpers for the sum accumulator block.
package sum_accumulator_pkg;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} acc_state_t;

  localparam int SAT_W = 32;

  // Fixed-width saturating add, returns {sat, result}; result is all ones on overflow.
  function automatic logic [SAT_W:0] sat_add(input logic [SAT_W-1:0] acc,
                                             input logic [SAT_W-1:0] in_v);
    logic [SAT_W:0] s;
    s = {1'b0, acc} + {1'b0, in_v};
    return s[SAT_W] ? {1'b1, {SAT_W{1'b1}}} : s;
  endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// Input handshake, flush and result handshake of the sum accumulator.
interface sum_accumulator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int MAX_COUNT  = 4
);
  import sum_accumulator_pkg::*;

  localparam int CNT_W = $clog2(MAX_COUNT + 1);

  logic                  in_valid;
  logic [DATA_WIDTH:0]   in_sum;
  logic                  in_ready;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_acc;
  logic [CNT_W-1:0]      out_count;
  logic                  out_sat;

  // Upstream adder / downstream stage side
  modport master (
    output in_valid, in_sum, flush, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_sat
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_sum, flush, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_sat
  );
endinterface

// File: rtl/sum_accumulator_sat_adder.sv
// Combinational acc + in with saturation to all ones on carry-out.
module sat_adder
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int IN_WIDTH  = 9
) (
  input  logic [ACC_WIDTH-1:0] i_acc,
  input  logic [IN_WIDTH-1:0]  i_in,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_sat
);
  logic [ACC_WIDTH:0] w_sum_ext;

  // One extra bit catches the carry that marks overflow
  always_comb begin
    w_sum_ext = {1'b0, i_acc} + (ACC_WIDTH + 1)'(i_in);
    o_sat     = w_sum_ext[ACC_WIDTH];
    o_sum     = o_sat ? {ACC_WIDTH{1'b1}} : w_sum_ext[ACC_WIDTH-1:0];
  end
endmodule

// File: rtl/sum_accumulator.sv
// Batches MAX_COUNT adder sums into a saturating total and hands it downstream.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int MAX_COUNT  = 4
) (
  input  logic            clk,
  input  logic            reset,
  sum_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_COUNT + 1);

  generate
    if (ACC_WIDTH < DATA_WIDTH + 1) begin : g_bad_acc_w
      $error("sum_accumulator: ACC_WIDTH must be >= DATA_WIDTH+1");
    end
    if (MAX_COUNT < 1) begin : g_bad_max_count
      $error("sum_accumulator: MAX_COUNT must be >= 1");
    end
  endgenerate

  acc_state_t           r_state, w_next;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sat;

  logic                 w_accum, w_beat, w_close, w_release;
  logic [ACC_WIDTH-1:0] w_add_sum;
  logic                 w_add_sat;

  sat_adder #(.ACC_WIDTH(ACC_WIDTH), .IN_WIDTH(DATA_WIDTH + 1)) u_add (
    .i_acc (r_acc),
    .i_in  (bus.in_sum),
    .o_sum (w_add_sum),
    .o_sat (w_add_sat)
  );

  assign w_accum   = (r_state == ACCUM);
  assign w_beat    = bus.in_valid && w_accum;
  // Batch closes on the last beat, or on flush when it would not be empty
  assign w_close   = (w_beat && (r_cnt == CNT_W'(MAX_COUNT - 1))) ||
                     (w_accum && bus.flush && ((r_cnt != '0) || w_beat));
  assign w_release = (r_state == DONE) && bus.out_ready;

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCUM:   if (w_close)   w_next = DONE;
      DONE:    if (w_release) w_next = ACCUM;
      default: w_next = ACCUM;
    endcase
  end

  // State, accumulator, count and sticky saturation flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_release) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else if (w_beat) begin
        r_acc <= w_add_sum;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_add_sat) r_sat <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_accum;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_acc   = r_acc;
  assign bus.out_count = r_cnt;
  assign bus.out_sat   = r_sat;
endmodule
